// File: rtl/i2c_write_controller.sv
// i2c_write_controller
//   Byte-level I2C master sequencer. It sits behind the baud-rate generator,
//   asks for the bit clock with BaudEnable and walks one transaction off the
//   ClockI2C square wave: START, address + R/W, ACK, data byte, ACK, STOP.
//
//   Optional feature macro: I2C_READ_EN. When defined it adds RW / ReadData
//   ports and a single-byte read (master NACKs the byte, then STOP).
//   Without it the R/W bit is fixed at 0 and the block is write-only.
//
// Ports
//   clock      system clock, rising edge
//   Reset      asynchronous active-low reset
//   Go         start request, honoured only while Busy=0
//   Address    slave address, latched on accepted Go
//   WriteData  payload byte, latched on accepted Go
//   RW         (I2C_READ_EN) R/W bit, latched on accepted Go
//   ReadData   (I2C_READ_EN) received byte, valid when Done pulses
//   ClockI2C   bit clock from the baud-rate generator
//   BaudEnable enable to the baud-rate generator
//   SDAIn      sampled SDA line
//   SCL        I2C clock line
//   SDAOut     SDA drive value (only meaningful when SDAOE=1)
//   SDAOE      SDA drive enable, 0 = released
//   Busy       transaction in progress
//   Done       one-clock pulse at end of transaction
//   AckError   sticky NACK flag, cleared by the next accepted Go
module i2c_write_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic                  Go,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
`ifdef I2C_READ_EN
  input  logic                  RW,
  output logic [DATA_WIDTH-1:0] ReadData,
`endif
  input  logic                  ClockI2C,
  output logic                  BaudEnable,
  input  logic                  SDAIn,
  output logic                  SCL,
  output logic                  SDAOut,
  output logic                  SDAOE,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AckError
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int CW  = $clog2((AW1 > DATA_WIDTH ? AW1 : DATA_WIDTH) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  clkq;
  logic [AW1-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_dec;
  // first-rise seen: START condition issued (START) / SCL parked high (STOP)
  logic                  phase_q, phase_d;
  logic                  rd_q, rd_d;
  logic                  rw_in;
  logic                  sdaout_d, sdaoe_d, busy_d, done_d, ack_d, baud_d;
  logic                  rise, fall;

`ifdef I2C_READ_EN
  assign rw_in = RW;
`else
  assign rw_in = 1'b0;
`endif

  assign rise    = ClockI2C & ~clkq;
  assign fall    = ~ClockI2C & clkq;
  assign cnt_dec = cnt_q - 1'b1;

  // SCL mirrors the registered bit clock while bits are on the wire; once
  // STOP has seen its rise the line stays high so SDA can rise under it.
  always_comb begin
    SCL = 1'b1;
    case (state_q)
      S_ADDR, S_ACK1, S_DATA, S_ACK2: SCL = clkq;
      S_STOP:                         SCL = phase_q ? 1'b1 : clkq;
      default:                        SCL = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      clkq       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      rd_q       <= 1'b0;
      SDAOut     <= 1'b1;
      SDAOE      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      AckError   <= 1'b0;
      BaudEnable <= 1'b0;
    end else begin
      state_q    <= state_d;
      clkq       <= ClockI2C;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      rd_q       <= rd_d;
      SDAOut     <= sdaout_d;
      SDAOE      <= sdaoe_d;
      Busy       <= busy_d;
      Done       <= done_d;
      AckError   <= ack_d;
      BaudEnable <= baud_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    rd_d     = rd_q;
    sdaout_d = SDAOut;
    sdaoe_d  = SDAOE;
    busy_d   = Busy;
    done_d   = 1'b0;
    ack_d    = AckError;
    baud_d   = BaudEnable;
    case (state_q)
      S_IDLE: if (Go) begin
        addr_d  = {Address, rw_in};
        data_d  = WriteData;
        rd_d    = rw_in;
        ack_d   = 1'b0;
        busy_d  = 1'b1;
        baud_d  = 1'b1;
        phase_d = 1'b0;
        state_d = S_START;
      end
      // A fall seen before the first rise is ignored: the generator may
      // start low, and START must be issued with SCL high.
      S_START: begin
        if (rise && !phase_q) begin
          sdaoe_d  = 1'b1;
          sdaout_d = 1'b0;
          phase_d  = 1'b1;
        end else if (fall && phase_q) begin
          sdaout_d = addr_q[AW1-1];
          addr_d   = {addr_q[AW1-2:0], 1'b0};
          cnt_d    = CW'(AW1);
          state_d  = S_ADDR;
        end
      end
      S_ADDR: if (fall) begin
        cnt_d = cnt_dec;
        if (cnt_dec != '0) begin
          sdaout_d = addr_q[AW1-1];
          addr_d   = {addr_q[AW1-2:0], 1'b0};
        end else begin
          sdaoe_d = 1'b0;
          state_d = S_ACK1;
        end
      end
      S_ACK1: begin
        if (rise && SDAIn) ack_d = 1'b1;
        if (fall) begin
          if (AckError) begin
            sdaoe_d  = 1'b1;
            sdaout_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = S_STOP;
          end else begin
            cnt_d   = CW'(DATA_WIDTH);
            state_d = S_DATA;
            if (!rd_q) begin
              sdaoe_d  = 1'b1;
              sdaout_d = data_q[DATA_WIDTH-1];
              data_d   = {data_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      S_DATA: if (fall) begin
        cnt_d = cnt_dec;
        if (cnt_dec != '0) begin
          if (!rd_q) begin
            sdaout_d = data_q[DATA_WIDTH-1];
            data_d   = {data_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = S_ACK2;
          // a read ends with a master NACK; a write hands SDA to the slave
          sdaoe_d  = rd_q;
          sdaout_d = 1'b1;
        end
      end
      S_ACK2: begin
        if (rise && SDAIn && !rd_q) ack_d = 1'b1;
        if (fall) begin
          sdaoe_d  = 1'b1;
          sdaout_d = 1'b0;
          phase_d  = 1'b0;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (rise && !phase_q) begin
          phase_d = 1'b1;
        end else if (fall && phase_q) begin
          sdaoe_d  = 1'b0;
          sdaout_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          baud_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef I2C_READ_EN
  logic [DATA_WIDTH-1:0] rd_sr;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset)                                rd_sr <= '0;
    else if (state_q == S_DATA && rd_q && rise) rd_sr <= {rd_sr[DATA_WIDTH-2:0], SDAIn};
  end

  assign ReadData = rd_sr;
`endif

endmodule

// File: tb/tb_i2c_write_controller.sv
// Directed bench for i2c_write_controller: a divide-by-8 bit clock source,
// a bus monitor that records START/STOP and the SDA value at every SCL rise,
// and a slave that answers the ACK slots (and returns a byte in read mode).
module tb_i2c_write_controller;
  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Go = 1'b0;
  logic [6:0] Address = '0;
  logic [7:0] WriteData = '0;
  logic       ClockI2C = 1'b0;
  logic       SDAIn;
  logic       BaudEnable, SCL, SDAOut, SDAOE, Busy, Done, AckError;
`ifdef I2C_READ_EN
  logic       RW = 1'b0;
  logic [7:0] ReadData;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  i2c_write_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .Address(Address), .WriteData(WriteData),
`ifdef I2C_READ_EN
    .RW(RW), .ReadData(ReadData),
`endif
    .ClockI2C(ClockI2C), .BaudEnable(BaudEnable), .SDAIn(SDAIn), .SCL(SCL),
    .SDAOut(SDAOut), .SDAOE(SDAOE), .Busy(Busy), .Done(Done), .AckError(AckError)
  );

  always #5 clock = ~clock;

  // bit clock: toggles every 4 clocks while enabled, unless frozen
  logic freeze = 1'b0;
  int   div = 0;
  always @(negedge clock) begin
    if (!BaudEnable) begin
      ClockI2C = 1'b0;
      div = 0;
    end else if (!freeze) begin
      if (div == 3) begin
        ClockI2C = ~ClockI2C;
        div = 0;
      end else div++;
    end
  end

  // wired-AND bus
  logic slave_drv = 1'b1;
  assign SDAIn = slave_drv & (SDAOE ? SDAOut : 1'b1);

  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       bits [0:31];
  int         nbits = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;
  logic       ack1_val = 1'b0, ack2_val = 1'b0, rd_mode = 1'b0;
  logic [7:0] slave_rd = '0;

  always @(negedge clock) begin
    logic sda;
    sda = (SDAOE ? SDAOut : 1'b1) & slave_drv;
    if (Done) done_cnt++;
    if (SCL && prev_scl && prev_sda && !sda) begin
      start_cnt++;
      nbits = 0;
    end else if (SCL && prev_scl && !prev_sda && sda) begin
      stop_cnt++;
    end else if (SCL && !prev_scl) begin
      if (nbits < 32) bits[nbits] = sda;
      nbits++;
    end else if (!SCL && prev_scl) begin
      if (nbits == 8)                              slave_drv = ack1_val;
      else if (nbits == 17)                        slave_drv = ack2_val;
      else if (rd_mode && nbits >= 9 && nbits <= 16) slave_drv = slave_rd[16-nbits];
      else                                         slave_drv = 1'b1;
    end
    prev_scl = SCL;
    prev_sda = sda;
  end

  function automatic logic [7:0] get_byte(input int s);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[6:0], bits[s+k]};
    return r;
  endfunction

  task automatic do_go(input int hold);
    @(negedge clock);
    Go = 1'b1;
    repeat (hold) @(negedge clock);
    Go = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if (SCL !== 1'b1)        begin n_fail++; $display("FAIL reset_scl: got %b want 1", SCL); end
    n_checks++; if (SDAOut !== 1'b1)     begin n_fail++; $display("FAIL reset_sdaout: got %b want 1", SDAOut); end
    n_checks++; if (SDAOE !== 1'b0)      begin n_fail++; $display("FAIL reset_sdaoe: got %b want 0", SDAOE); end
    n_checks++; if (BaudEnable !== 1'b0) begin n_fail++; $display("FAIL reset_baud: got %b want 0", BaudEnable); end
    n_checks++; if (Busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (Done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (AckError !== 1'b0)   begin n_fail++; $display("FAIL reset_ackerr: got %b want 0", AckError); end
    Reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write_ack;
    int b_st, b_sp, b_d;
    bit ok;
    ack1_val = 1'b0; ack2_val = 1'b0;
    Address = 7'h50; WriteData = 8'hA5;
    b_st = start_cnt; b_sp = stop_cnt; b_d = done_cnt;
    do_go(1);
    n_checks++; if (Busy !== 1'b1)       begin n_fail++; $display("FAIL wr_busy_rise: got %b want 1", Busy); end
    n_checks++; if (BaudEnable !== 1'b1) begin n_fail++; $display("FAIL wr_baud_on: got %b want 1", BaudEnable); end
    wait_done(b_d, ok);
    n_checks++; if (!ok)                    begin n_fail++; $display("FAIL wr_done_timeout: got no Done want Done"); end
    n_checks++; if (get_byte(0) !== 8'hA0)  begin n_fail++; $display("FAIL wr_addr_frame: got %h want a0", get_byte(0)); end
    n_checks++; if (bits[8] !== 1'b0)       begin n_fail++; $display("FAIL wr_ack1_bit: got %b want 0", bits[8]); end
    n_checks++; if (get_byte(9) !== 8'hA5)  begin n_fail++; $display("FAIL wr_data: got %h want a5", get_byte(9)); end
    n_checks++; if (bits[17] !== 1'b0)      begin n_fail++; $display("FAIL wr_ack2_bit: got %b want 0", bits[17]); end
    n_checks++; if (nbits !== 19)           begin n_fail++; $display("FAIL wr_nbits: got %0d want 19", nbits); end
    n_checks++; if (start_cnt - b_st !== 1) begin n_fail++; $display("FAIL wr_starts: got %0d want 1", start_cnt - b_st); end
    n_checks++; if (stop_cnt - b_sp !== 1)  begin n_fail++; $display("FAIL wr_stops: got %0d want 1", stop_cnt - b_sp); end
    n_checks++; if (AckError !== 1'b0)      begin n_fail++; $display("FAIL wr_ackerr: got %b want 0", AckError); end
    n_checks++; if (BaudEnable !== 1'b0)    begin n_fail++; $display("FAIL wr_baud_off: got %b want 0", BaudEnable); end
    n_checks++; if (Busy !== 1'b0)          begin n_fail++; $display("FAIL wr_busy_fall: got %b want 0", Busy); end
    repeat (20) @(negedge clock);
    #1;
    n_checks++; if (done_cnt - b_d !== 1)   begin n_fail++; $display("FAIL wr_done_once: got %0d want 1", done_cnt - b_d); end
  endtask

  task automatic test_addr_nack;
    int b_sp, b_d;
    bit ok;
    ack1_val = 1'b1; ack2_val = 1'b0;
    Address = 7'h50; WriteData = 8'hA5;
    b_sp = stop_cnt; b_d = done_cnt;
    do_go(1);
    wait_done(b_d, ok);
    n_checks++; if (!ok)                   begin n_fail++; $display("FAIL nack_done_timeout: got no Done want Done"); end
    n_checks++; if (AckError !== 1'b1)     begin n_fail++; $display("FAIL nack_ackerr: got %b want 1", AckError); end
    n_checks++; if (get_byte(0) !== 8'hA0) begin n_fail++; $display("FAIL nack_addr_frame: got %h want a0", get_byte(0)); end
    n_checks++; if (bits[8] !== 1'b1)      begin n_fail++; $display("FAIL nack_ack1_bit: got %b want 1", bits[8]); end
    n_checks++; if (nbits !== 10)          begin n_fail++; $display("FAIL nack_nbits: got %0d want 10", nbits); end
    n_checks++; if (stop_cnt - b_sp !== 1) begin n_fail++; $display("FAIL nack_stops: got %0d want 1", stop_cnt - b_sp); end
    n_checks++; if (done_cnt - b_d !== 1)  begin n_fail++; $display("FAIL nack_done_once: got %0d want 1", done_cnt - b_d); end
    ack1_val = 1'b0;
    b_d = done_cnt;
    do_go(1);
    n_checks++; if (AckError !== 1'b0)     begin n_fail++; $display("FAIL nack_clear_on_go: got %b want 0", AckError); end
    wait_done(b_d, ok);
    n_checks++; if (!ok || AckError !== 1'b0) begin n_fail++; $display("FAIL nack_recover: got ok=%b ackerr=%b want ok=1 ackerr=0", ok, AckError); end
  endtask

  task automatic test_go_hold;
    int b_st, b_d;
    bit ok;
    ack1_val = 1'b0; ack2_val = 1'b0;
    Address = 7'h2B; WriteData = 8'h3C;
    b_st = start_cnt; b_d = done_cnt;
    do_go(3);
    Address = 7'h7F; WriteData = 8'h00;
    repeat (60) @(negedge clock);
    Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
    wait_done(b_d, ok);
    n_checks++; if (!ok)                    begin n_fail++; $display("FAIL hold_done_timeout: got no Done want Done"); end
    n_checks++; if (get_byte(0) !== 8'h56)  begin n_fail++; $display("FAIL hold_addr_frame: got %h want 56", get_byte(0)); end
    n_checks++; if (get_byte(9) !== 8'h3C)  begin n_fail++; $display("FAIL hold_data: got %h want 3c", get_byte(9)); end
    repeat (300) @(negedge clock);
    #1;
    n_checks++; if (done_cnt - b_d !== 1)   begin n_fail++; $display("FAIL hold_one_txn: got %0d want 1", done_cnt - b_d); end
    n_checks++; if (start_cnt - b_st !== 1) begin n_fail++; $display("FAIL hold_one_start: got %0d want 1", start_cnt - b_st); end
    n_checks++; if (Busy !== 1'b0)          begin n_fail++; $display("FAIL hold_idle: got %b want 0", Busy); end
  endtask

  task automatic test_reset_mid;
    int b_st, b_d;
    bit ok, hit;
    ack1_val = 1'b0; ack2_val = 1'b0;
    Address = 7'h50; WriteData = 8'hA5;
    b_st = start_cnt;
    do_go(1);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      if (start_cnt > b_st && nbits == 13) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach_bit4: got timeout want data bit 4"); end
    Reset = 1'b0;
    #1;
    n_checks++; if (SCL !== 1'b1)        begin n_fail++; $display("FAIL rst_mid_scl: got %b want 1", SCL); end
    n_checks++; if (SDAOE !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_sdaoe: got %b want 0", SDAOE); end
    n_checks++; if (Busy !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    n_checks++; if (BaudEnable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_baud: got %b want 0", BaudEnable); end
    repeat (3) @(negedge clock);
    Reset = 1'b1;
    repeat (2) @(negedge clock);
    Address = 7'h11; WriteData = 8'hC3;
    b_d = done_cnt;
    do_go(1);
    wait_done(b_d, ok);
    n_checks++; if (!ok)                   begin n_fail++; $display("FAIL rst_after_done_timeout: got no Done want Done"); end
    n_checks++; if (get_byte(0) !== 8'h22) begin n_fail++; $display("FAIL rst_after_addr: got %h want 22", get_byte(0)); end
    n_checks++; if (get_byte(9) !== 8'hC3) begin n_fail++; $display("FAIL rst_after_data: got %h want c3", get_byte(9)); end
    n_checks++; if (nbits !== 19 || AckError !== 1'b0) begin n_fail++; $display("FAIL rst_after_clean: got nbits=%0d ackerr=%b want 19/0", nbits, AckError); end
  endtask

  task automatic test_freeze;
    int b_st, b_d, nb, changes;
    bit ok, hit;
    logic s_scl, s_out, s_oe;
    ack1_val = 1'b0; ack2_val = 1'b0;
    Address = 7'h6A; WriteData = 8'h5A;
    b_st = start_cnt; b_d = done_cnt;
    do_go(1);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #2;
      if (start_cnt > b_st && nbits == 3 && ClockI2C == 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    freeze = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    s_scl = SCL; s_out = SDAOut; s_oe = SDAOE; nb = nbits;
    changes = 0;
    repeat (47) begin
      @(negedge clock);
      #1;
      if (SCL !== s_scl || SDAOut !== s_out || SDAOE !== s_oe) changes++;
    end
    n_checks++; if (!hit)         begin n_fail++; $display("FAIL frz_reach_addr: got timeout want addr bit 3"); end
    n_checks++; if (changes !== 0) begin n_fail++; $display("FAIL frz_stable: got %0d changes want 0", changes); end
    n_checks++; if (nbits !== nb || Busy !== 1'b1) begin n_fail++; $display("FAIL frz_held: got nbits=%0d busy=%b want %0d/1", nbits, Busy, nb); end
    freeze = 1'b0;
    wait_done(b_d, ok);
    n_checks++; if (!ok)                   begin n_fail++; $display("FAIL frz_done_timeout: got no Done want Done"); end
    n_checks++; if (get_byte(0) !== 8'hD4) begin n_fail++; $display("FAIL frz_addr: got %h want d4", get_byte(0)); end
    n_checks++; if (get_byte(9) !== 8'h5A) begin n_fail++; $display("FAIL frz_data: got %h want 5a", get_byte(9)); end
    n_checks++; if (nbits !== 19)          begin n_fail++; $display("FAIL frz_nbits: got %0d want 19", nbits); end
  endtask

`ifdef I2C_READ_EN
  task automatic test_read;
    int b_d;
    bit ok;
    ack1_val = 1'b0; ack2_val = 1'b1;
    rd_mode = 1'b1; slave_rd = 8'h3C;
    RW = 1'b1; Address = 7'h50; WriteData = 8'hFF;
    b_d = done_cnt;
    do_go(1);
    wait_done(b_d, ok);
    n_checks++; if (!ok)                   begin n_fail++; $display("FAIL rd_done_timeout: got no Done want Done"); end
    n_checks++; if (get_byte(0) !== 8'hA1) begin n_fail++; $display("FAIL rd_addr_frame: got %h want a1", get_byte(0)); end
    n_checks++; if (ReadData !== 8'h3C)    begin n_fail++; $display("FAIL rd_data: got %h want 3c", ReadData); end
    n_checks++; if (bits[17] !== 1'b1)     begin n_fail++; $display("FAIL rd_master_nack: got %b want 1", bits[17]); end
    n_checks++; if (nbits !== 19)          begin n_fail++; $display("FAIL rd_nbits: got %0d want 19", nbits); end
    rd_mode = 1'b0; RW = 1'b0; ack2_val = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_write_ack;
    test_addr_nack;
    test_go_hold;
    test_reset_mid;
    test_freeze;
`ifdef I2C_READ_EN
    test_read;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_write_controller.md
Name: i2c_write_controller

Overview:
- Byte-level I2C master sequencer directly downstream of the I2C baud-rate generator.
- Requests the I2C bit clock (`BaudEnable`) and consumes the generator's square wave `ClockI2C`.
- Produces `SCL`/`SDA` for one write transaction: START, 7-bit address + R/W=0, ACK, data byte, ACK, STOP.
- Reports `Busy`, `Done` and `AckError` to the host logic.

Parameters:
- DATA_WIDTH, 8, width of the payload byte and receive register.
- ADDR_WIDTH, 7, slave address width; the address frame is ADDR_WIDTH+1 bits including R/W.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Go  input  1  start request, sampled while Busy=0.
- Address  input  ADDR_WIDTH  slave address, latched on an accepted Go.
- WriteData  input  DATA_WIDTH  payload, latched on an accepted Go.
- ClockI2C  input  1  bit clock from the baud-rate generator.
- BaudEnable  output  1  enable to the baud-rate generator.
- SDAIn  input  1  sampled SDA line, from the slave or bench.
- SCL  output  1  I2C clock line.
- SDAOut  output  1  SDA drive value; meaningful only when SDAOE=1.
- SDAOE  output  1  SDA drive enable; 0 means released (pulled high externally).
- Busy  output  1  transaction in progress.
- Done  output  1  one-clock pulse at end of transaction.
- AckError  output  1  sticky NACK flag; cleared on the next accepted Go.

Behaviour:
- Reset (Reset=0, asynchronous) values:
  - State=IDLE, SCL=1, SDAOut=1, SDAOE=0, BaudEnable=0, Busy=0, Done=0, AckError=0.
  - Shift register and bit counter cleared.
- Edge detection:
  - ClockI2C is registered once (ClkQ).
  - rise = ClockI2C & ~ClkQ; fall = ~ClockI2C & ClkQ.
  - Each edge is a one-clock pulse.
- SCL output:
  - SCL = ClkQ in ADDR, ACK1, DATA, ACK2.
  - SCL = 1 in IDLE and START.
  - In STOP, SCL follows ClkQ until the first rise in STOP, then is held at 1.
- States and transitions:
  - IDLE:
    - Go=1 → latch {Address, 1'b0} into shift register and WriteData into data register.
    - Clear AckError; set Busy=1 and BaudEnable=1 on the next edge; go to START.
  - START:
    - On the first rise, drive SDAOE=1, SDAOut=0 (START condition, SCL high).
    - On the following fall, go to ADDR, put the MSB on SDAOut, set the bit counter to ADDR_WIDTH+1.
  - ADDR:
    - On each fall, decrement the counter.
    - If the counter is nonzero, shift the next bit onto SDAOut.
    - When the counter reaches 0, set SDAOE=0 and go to ACK1.
  - ACK1:
    - On rise, sample SDAIn; 1 sets AckError.
    - On the next fall:
      - If AckError=1: SDAOE=1, SDAOut=0, go to STOP.
      - Otherwise: load WriteData MSB, counter=DATA_WIDTH, go to DATA.
  - DATA: same bit rules as ADDR; exit to ACK2.
  - ACK2:
    - On rise, sample SDAIn; 1 sets AckError.
    - On the next fall: SDAOE=1, SDAOut=0, go to STOP.
  - STOP:
    - On the first rise, SCL is held at 1.
    - On the next fall, SDAOE=0 (STOP condition).
    - Also: Done=1 for one clock, Busy=0, BaudEnable=0, go to IDLE.
- SDA timing: SDA changes only on fall while SCL is low, except the START and STOP transitions, which occur with SCL=1.
- Go while Busy=1 is ignored. Inputs are not re-sampled mid-transfer.
- Reset asserted mid-transfer immediately forces the reset values: bus released, no STOP generated.
- If ClockI2C stops toggling, the FSM waits indefinitely. There is no timeout.
- Latency: Busy rises 1 clock after Go. Done occurs 19 ClockI2C periods + ≤1 period after Go (8 addr + 1 ack + 8 data + 1 ack + start/stop), for the default widths.

Optional Feature:
- Macro: I2C_READ_EN.
- When defined:
  - Adds input RW: R/W bit = RW, latched on Go.
  - Adds output ReadData [DATA_WIDTH-1:0], reset 0.
  - With RW=1, the DATA state releases SDA (SDAOE=0) and shifts SDAIn into ReadData MSB-first on each rise.
  - ACK2 becomes a master NACK: SDAOE=1, SDAOut=1 for one bit, then STOP.
  - ReadData is valid when Done pulses.
- When undefined: R/W bit is fixed at 0, no RW/ReadData ports, write-only.

Test Plan:
- Write with ACK: Address=7'h50, WriteData=8'hA5, ClockI2C period 8 clocks, bench drives SDAIn=0 in ACK slots.
  - SDA shows START, 1010000 0, release, 10100101, release, STOP.
  - Done pulses once, AckError=0, BaudEnable low after Done.
- Address NACK: same stimulus, SDAIn=1 during ACK1.
  - AckError=1; STOP follows directly with no data bits.
  - Done pulses; the next Go clears AckError.
- Go held high for 3 clocks, then pulsed again mid-transfer.
  - Exactly one transaction; second Go ignored; the latched Address/WriteData are not affected by input changes.
- Reset=0 asserted during DATA bit 4.
  - Same clock: SCL=1, SDAOE=0, Busy=0, BaudEnable=0.
  - After release, the next Go runs a clean full transaction.
- ClockI2C held at 0 for 50 clocks mid-ADDR: FSM frozen, SDA stable; resumes correctly when toggling restarts.
- I2C_READ_EN with RW=1, slave returns 8'h3C:
  - Address frame ends in 1.
  - ReadData=8'h3C at Done; master NACK bit is SDA=1.
